ccff_chain_loader: RTL and testbench

- Programming controller that serially loads a configuration bitstream into the fabric's configuration flip-flop chain (ccff_head to ccff_tail through the CLB and routing tiles).
- Accepts bitstream words over a valid/ready stream, serialises them MSB-first, and gates chain shifting one bit per enabled cycle.
- After loading, performs a circular readback pass that restores the chain and compares a CRC of the returned bits with the CRC of the loaded bits.
- Sits between the secure bitstream decrypt/unpack path and the fabric top-level programming ports.

---
 rtl/ccff_chain_loader.sv | 126 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Serial loader for the fabric configuration flip-flop chain: streams bitstream
// words MSB-first into ccff_head, then recirculates the chain once to CRC-check it.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int unsigned   CW   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned   BW   = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, ERR} state_t;

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     req_left;
  logic [WORD_W-1:0] buf_q;
  logic [BW-1:0]     buf_left;
  logic [15:0]       load_crc;
  logic [15:0]       rb_crc;
  logic              bit_avail;
  logic              xfer;
  logic [BW-1:0]     take;

  // CRC-16-CCITT (0x1021), one bit per call, MSB-first
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // A new word is taken while the last buffered bit drains, so a steady source
  // never leaves a bubble; take counts only the bits the chain still needs.
  always_comb begin
    bit_avail = (buf_left != '0);
    bs_ready  = (state == LOAD) && (buf_left <= BW'(1)) && (req_left != '0);
    xfer      = bs_ready && bs_valid;
    take      = (32'(req_left) >= WORD_W) ? BW'(WORD_W) : BW'(req_left);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      req_left      <= '0;
      buf_q         <= '0;
      buf_left      <= '0;
      load_crc      <= '1;
      rb_crc        <= '1;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      crc_err       <= 1'b0;
    end else begin
      ccff_shift_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= LOAD;
            bit_cnt       <= '0;
            req_left      <= LAST;
            buf_left      <= '0;
            load_crc      <= '1;
            rb_crc        <= '1;
            config_enable <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            crc_err       <= 1'b0;
          end
        end
        LOAD: begin
          if (bit_avail) begin
            ccff_head     <= buf_q[WORD_W-1];
            ccff_shift_en <= 1'b1;
            bit_cnt       <= bit_cnt + CW'(1);
            load_crc      <= crc_step(load_crc, buf_q[WORD_W-1]);
            buf_q         <= buf_q << 1;
            buf_left      <= buf_left - BW'(1);
          end
          if (xfer) begin
            buf_q    <= bs_data;
            buf_left <= take;
            req_left <= req_left - CW'(take);
          end
          if (bit_cnt == LAST) begin
            state   <= VERIFY;
            bit_cnt <= '0;
          end
        end
        VERIFY: begin
          // Chain shifts on the opposite phase, so the tail seen here is the
          // bit leaving the chain; feeding it back to head restores the chain.
          if (bit_cnt == LAST) begin
            state         <= (rb_crc == load_crc) ? DONE : ERR;
            done          <= (rb_crc == load_crc);
            crc_err       <= (rb_crc != load_crc);
            config_enable <= 1'b0;
            busy          <= 1'b0;
            bit_cnt       <= '0;
          end else begin
            ccff_head     <= ccff_tail;
            ccff_shift_en <= 1'b1;
            rb_crc        <= crc_step(rb_crc, ccff_tail);
            bit_cnt       <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: two instances (24-bit and 20-bit chains)
// each driving a behavioural chain that advances on the falling clock edge.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       start    [2];
  logic [7:0] bs_data  [2];
  logic       bs_valid [2];
  logic       bs_ready [2];
  logic       head     [2];
  logic       tail     [2];
  logic       shift_en [2];
  logic       cfg_en   [2];
  logic       busy     [2];
  logic       done     [2];
  logic       crc_err  [2];
  logic [23:0] chain0   = '0;
  logic [19:0] chain1   = '0;
  logic        flip_req = 1'b0;
  logic [7:0]  wd [2][3];
  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut0 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start[0]), .bs_data(bs_data[0]),
    .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]), .ccff_head(head[0]),
    .ccff_tail(tail[0]), .ccff_shift_en(shift_en[0]), .config_enable(cfg_en[0]),
    .busy(busy[0]), .done(done[0]), .crc_err(crc_err[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut1 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start[1]), .bs_data(bs_data[1]),
    .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]), .ccff_head(head[1]),
    .ccff_tail(tail[1]), .ccff_shift_en(shift_en[1]), .config_enable(cfg_en[1]),
    .busy(busy[1]), .done(done[1]), .crc_err(crc_err[1])
  );

  // chain[0] sits next to the head, the last index is the tail
  always @(negedge prog_clk) begin
    if (shift_en[0]) chain0 <= {chain0[22:0], head[0]};
    else if (flip_req) chain0 <= chain0 ^ 24'h000400;
  end
  always @(negedge prog_clk) begin
    if (shift_en[1]) chain1 <= {chain1[18:0], head[1]};
  end
  assign tail[0] = chain0[23];
  assign tail[1] = chain1[19];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_words(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    wd[idx][0] = a;
    wd[idx][1] = b;
    wd[idx][2] = c;
  endtask

  function automatic logic sbit(input int idx, input int k);
    logic [7:0] w;
    w = wd[idx][k / 8];
    return w[7 - (k % 8)];
  endfunction

  task automatic run(input string name, input int idx, input int n, input bit stall,
                     input bit corrupt, input bit poke, input bit exp_err,
                     input logic [23:0] exp_chain);
    int nx = 0, issued = 0, rb = 0, avail = 0, reqleft = n, wi = 0, ph = 0, tk = 0;
    int sh_bad = 0, head_bad = 0, hold_bad = 0, first_sh = -1, last_sh = -1;
    int xcyc [4] = '{default: 0};
    logic exp_sh = 1'b0, last_head = 1'b0, xf;
    @(posedge prog_clk); #1;
    start[idx] = 1'b1;
    bs_valid[idx] = 1'b0;
    @(posedge prog_clk); #1;
    start[idx] = 1'b0;
    bs_valid[idx] = 1'b1;
    bs_data[idx] = wd[idx][0];
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge prog_clk);
      if (ph == 0) begin
        if (shift_en[idx] !== exp_sh) sh_bad++;
        if (shift_en[idx]) begin
          if (head[idx] !== sbit(idx, issued)) head_bad++;
          if (first_sh < 0) first_sh = cyc;
          last_sh = cyc;
          issued++;
        end else if (cyc > 0 && head[idx] !== last_head) hold_bad++;
        last_head = head[idx];
        xf = bs_valid[idx] & bs_ready[idx];
        exp_sh = (avail > 0);
        if (avail > 0) avail--;
        if (xf) begin
          if (nx < 4) xcyc[nx] = cyc;
          nx++;
          wi++;
          tk = (reqleft >= 8) ? 8 : reqleft;
          avail += tk;
          reqleft -= tk;
        end
        if (issued == n) ph = 1;
      end else if (ph == 1) begin
        if (shift_en[idx] !== 1'b0) sh_bad++;
        check({name, "_active"}, {30'd0, cfg_en[idx], busy[idx]}, 32'd3);
        ph = 2;
      end else begin
        if (shift_en[idx]) begin
          if (!corrupt && head[idx] !== sbit(idx, rb)) head_bad++;
          rb++;
        end else ph = 3;
      end
      if (ph == 3) break;
      @(posedge prog_clk); #1;
      flip_req = corrupt && (ph == 1);
      start[idx] = poke && ((ph == 0 && cyc == 10) || (ph == 2 && rb == 5));
      bs_valid[idx] = stall ? (((cyc + 1) / 3) % 2 == 0) : 1'b1;
      bs_data[idx] = (wi < 3) ? wd[idx][wi] : 8'h00;
    end
    check({name, "_finished"}, ph, 3);
    check({name, "_xfers"}, nx, 3);
    check({name, "_load_bits"}, issued, n);
    check({name, "_verify_bits"}, rb, n);
    check({name, "_shift_pattern"}, sh_bad, 0);
    check({name, "_head_bits"}, head_bad, 0);
    check({name, "_head_hold"}, hold_bad, 0);
    if (!stall) begin
      check({name, "_load_span"}, last_sh - first_sh + 1, n);
      check({name, "_xfer_gap"}, xcyc[2] - xcyc[0], 16);
    end
    check({name, "_status"}, {29'd0, busy[idx], done[idx], crc_err[idx]},
          exp_err ? 32'd1 : 32'd2);
    check({name, "_cfg_off"}, cfg_en[idx], 0);
    check({name, "_chain"}, (idx == 0) ? {8'd0, chain0} : {12'd0, chain1}, {8'd0, exp_chain});
  endtask

  initial begin
    pReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      bs_valid[i] = 1'b0;
      bs_data[i] = 8'h00;
    end
    repeat (3) @(posedge prog_clk);
    #1;
    check("reset_outs0", {25'd0, bs_ready[0], head[0], shift_en[0], cfg_en[0], busy[0],
                          done[0], crc_err[0]}, 0);
    check("reset_outs1", {25'd0, bs_ready[1], head[1], shift_en[1], cfg_en[1], busy[1],
                          done[1], crc_err[1]}, 0);
    pReset = 1'b0;

    set_words(0, 8'hA5, 8'h3C, 8'hF0);
    run("t1_contig", 0, 24, 0, 0, 0, 0, 24'hA53CF0);

    set_words(1, 8'hFF, 8'h00, 8'hC3);
    run("t2_partial", 1, 20, 0, 0, 0, 0, 24'h0FF00C);

    set_words(0, 8'h5A, 8'hC3, 8'h96);
    run("t3_stall", 0, 24, 1, 0, 0, 0, 24'h5AC396);

    set_words(0, 8'hA5, 8'h3C, 8'hF0);
    run("t4_corrupt", 0, 24, 0, 1, 0, 1, 24'hA538F0);
    set_words(0, 8'h12, 8'h34, 8'h56);
    run("t4_retry", 0, 24, 0, 0, 0, 0, 24'h123456);

    set_words(0, 8'h0F, 8'h1E, 8'h2D);
    run("t5_poke", 0, 24, 0, 0, 1, 0, 24'h0F1E2D);

    @(posedge prog_clk); #1;
    start[0] = 1'b1;
    bs_valid[0] = 1'b1;
    bs_data[0] = 8'h96;
    @(posedge prog_clk); #1;
    start[0] = 1'b0;
    repeat (10) @(posedge prog_clk);
    #2;
    check("t6_busy_mid", busy[0], 1);
    pReset = 1'b1;
    #1;
    check("t6_reset_outs", {25'd0, bs_ready[0], head[0], shift_en[0], cfg_en[0], busy[0],
                            done[0], crc_err[0]}, 0);
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check("t6_idle_after", {29'd0, bs_ready[0], busy[0], done[0]}, 0);
    set_words(0, 8'hC0, 8'hFF, 8'hEE);
    run("t6_reload", 0, 24, 0, 0, 0, 0, 24'hC0FFEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
